// File: rtl/jtkiwi_pal_pkg.sv
// jtkiwi_pal_pkg: shared widths, FSM states and address helper for the palette arbiter
package jtkiwi_pal_pkg;
    localparam int PAL_AW = 10;
    localparam int COL_W  = 9;
    localparam int RGB_W  = 5;
    localparam int HI_SEL = 9;

    typedef enum logic [1:0] {IDLE, VRD_LO, VRD_HI, VCAP} state_e;

    function automatic logic [PAL_AW-1:0] pal_addr(input logic hi, input logic [COL_W-1:0] col);
        logic [PAL_AW-1:0] a;
        a = {1'b0, col};
        a[HI_SEL] = hi;
        return a;
    endfunction
endpackage

// File: rtl/jtkiwi_pal_cpu_if.sv
// jtkiwi_pal_cpu_if: CPU-side acknowledge, read return and one-access-per-cs tracking
module jtkiwi_pal_cpu_if
    import jtkiwi_pal_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_cs_i,
    input  logic       cpu_rnw_i,
    input  logic       grant_i,
    input  logic [7:0] ram_dout_i,
    output logic [7:0] cpu_din_o,
    output logic       cpu_ok_o,
    output logic       busy_o
);
    logic       wr_q, rd1_q, rd2_q, ok_q, done_q;
    logic [7:0] din_q;

    // a read needs the RAM's registered output, so its ack lands one clk after a write's would
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {wr_q, rd1_q, rd2_q, ok_q, done_q} <= '0;
            din_q <= '0;
        end else begin
            wr_q   <= grant_i & ~cpu_rnw_i;
            rd1_q  <= grant_i & cpu_rnw_i;
            rd2_q  <= rd1_q;
            ok_q   <= wr_q | rd2_q;
            din_q  <= rd2_q ? ram_dout_i : din_q;
            done_q <= ok_q | (done_q & cpu_cs_i);
        end
    end

    assign cpu_din_o = din_q;
    assign cpu_ok_o  = ok_q;
    assign busy_o    = wr_q | rd1_q | rd2_q | ok_q | done_q;
endmodule

// File: rtl/jtkiwi_pal_arb.sv
// jtkiwi_pal_arb: palette RAM sequencer; two video byte reads per pixel, CPU fills idle slots
module jtkiwi_pal_arb
    import jtkiwi_pal_pkg::*;
#(
    parameter bit BLANK_BLACK    = 1'b1,
    parameter bit CPU_BLANK_ONLY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pxl_cen,
    input  logic              LHBL,
    input  logic              LVBL,
    input  logic [COL_W-1:0]  col_addr,
    input  logic              cpu_cs,
    input  logic              cpu_rnw,
    input  logic [PAL_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              cpu_ok,
    output logic [PAL_AW-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout,
    output logic [RGB_W-1:0]  red,
    output logic [RGB_W-1:0]  green,
    output logic [RGB_W-1:0]  blue
);
    state_e              state_q;
    logic [COL_W-1:0]    coll_q;
    logic [7:0]          lo_q;
    logic [3*RGB_W-1:0]  rgb_nx_q, rgb_q;
    logic [PAL_AW-1:0]   ram_addr_q;
    logic [7:0]          ram_din_q;
    logic                ram_we_q;
    logic                busy, grant, blank;

    assign blank = ~LHBL | ~LVBL;
    // video wins a tie with the CPU, so a pending pxl_cen blocks the grant
    assign grant = state_q == IDLE && !pxl_cen && cpu_cs && !busy && (CPU_BLANK_ONLY == 1'b0 || blank);

    jtkiwi_pal_cpu_if u_cpu_if (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_cs_i   (cpu_cs),
        .cpu_rnw_i  (cpu_rnw),
        .grant_i    (grant),
        .ram_dout_i (ram_dout),
        .cpu_din_o  (cpu_din),
        .cpu_ok_o   (cpu_ok),
        .busy_o     (busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            coll_q     <= '0;
            lo_q       <= '0;
            rgb_nx_q   <= '0;
            rgb_q      <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
        end else begin
            ram_we_q <= grant & ~cpu_rnw;
            if (grant) begin
                ram_addr_q <= cpu_addr;
                ram_din_q  <= cpu_dout;
            end
            if (pxl_cen) rgb_q <= (BLANK_BLACK && blank) ? '0 : rgb_nx_q;
            case (state_q)
                IDLE: if (pxl_cen) begin
                    state_q    <= VRD_LO;
                    coll_q     <= col_addr;
                    ram_addr_q <= pal_addr(1'b0, col_addr);
                end
                VRD_LO: begin
                    state_q    <= VRD_HI;
                    ram_addr_q <= pal_addr(1'b1, coll_q);
                end
                VRD_HI: begin
                    state_q <= VCAP;
                    lo_q    <= ram_dout;
                end
                default: begin
                    state_q  <= IDLE;
                    rgb_nx_q <= {ram_dout[6:0], lo_q};
                end
            endcase
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_we   = ram_we_q;
    assign red      = rgb_q[3*RGB_W-1 -: RGB_W];
    assign green    = rgb_q[2*RGB_W-1 -: RGB_W];
    assign blue     = rgb_q[RGB_W-1:0];

    a_pxl_idle: assert property (@(posedge clk) disable iff (!rst_n) pxl_cen |-> state_q == IDLE);
endmodule

// File: tb/tb_jtkiwi_pal_arb.sv
// tb_jtkiwi_pal_arb: directed bench with a palette/pixel model checked every clk
module tb_jtkiwi_pal_arb;
    logic       clk = 0, rst_n = 0, pxl_cen = 0, LHBL = 1, LVBL = 1;
    logic [8:0] col_addr = 0;
    logic       cpu_cs = 0, cpu_rnw = 1;
    logic [9:0] cpu_addr = 0;
    logic [7:0] cpu_dout = 0;
    logic [7:0] cpu_din, ram_din, ram_dout;
    logic       cpu_ok, ram_we;
    logic [9:0] ram_addr;
    logic [4:0] red, green, blue;

    logic       cs2 = 0;
    logic [7:0] din2, ramdin2;
    logic [7:0] rd2 = 8'h00;
    logic       ok2, we2;
    logic [9:0] ra2;
    logic [4:0] r2, g2, b2;

    int checks = 0, errors = 0, we_cnt = 0, ok_cnt = 0;
    logic [7:0]  mem [1024];
    logic [7:0]  pal [1024];
    logic [14:0] exp_rgb = 0, nxt_rgb = 0;
    int          vcnt = 0;
    logic [8:0]  vcol = 0;

    always #5 clk = ~clk;

    jtkiwi_pal_arb #(.BLANK_BLACK(1'b1), .CPU_BLANK_ONLY(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL), .col_addr(col_addr),
        .cpu_cs(cpu_cs), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .cpu_ok(cpu_ok), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout), .red(red), .green(green), .blue(blue));

    jtkiwi_pal_arb #(.BLANK_BLACK(1'b1), .CPU_BLANK_ONLY(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL), .col_addr(col_addr),
        .cpu_cs(cs2), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_din(din2), .cpu_ok(ok2), .ram_addr(ra2), .ram_din(ramdin2), .ram_we(we2),
        .ram_dout(rd2), .red(r2), .green(g2), .blue(b2));

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // pixel model: colour of the pixel sampled one pxl_cen earlier, blanked at the current one
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_rgb <= 0;
            nxt_rgb <= 0;
            vcnt    <= 0;
        end else if (pxl_cen) begin
            exp_rgb <= (!LHBL || !LVBL) ? 15'd0 : nxt_rgb;
            nxt_rgb <= {pal[{1'b1, col_addr}][6:0], pal[{1'b0, col_addr}]};
            vcnt    <= 3;
            vcol    <= col_addr;
        end else if (vcnt != 0) vcnt <= vcnt - 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("rgb", {red, green, blue}, exp_rgb);
        if (ram_we) begin
            we_cnt++;
            check("we_addr", ram_addr, cpu_addr);
            check("we_din", ram_din, cpu_dout);
            check("we_cs", {cpu_cs, cpu_rnw}, 2'b10);
        end
        if (cpu_ok) ok_cnt++;
        if (vcnt != 0) check("we_in_video", ram_we, 0);
        if (vcnt == 3) check("vid_lo_addr", ram_addr, {1'b0, vcol});
        if (vcnt == 2) check("vid_hi_addr", ram_addr, {1'b1, vcol});
    end

    task automatic pix(input logic [8:0] c, input int gap);
        col_addr = c;
        pxl_cen  = 1;
        @(posedge clk); #1 pxl_cen = 0;
        repeat (gap - 1) @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic rnw, input logic [9:0] a, input logic [7:0] d, output logic [7:0] q);
        int w0, n;
        w0 = we_cnt;
        n  = 0;
        cpu_cs = 1; cpu_rnw = rnw; cpu_addr = a; cpu_dout = d;
        do begin @(negedge clk); n++; end while (!cpu_ok && n < 20);
        check("cpu_ack", cpu_ok, 1);
        q = cpu_din;
        @(posedge clk); #1 cpu_cs = 0;
        if (!rnw) pal[a] = d;
        check("cpu_we_pulses", we_cnt - w0, rnw ? 0 : 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] q;
        int n, w0, o0;
        foreach (pal[i]) pal[i] = 0;
        // reset with a write request already pending
        cpu_cs = 1; cpu_rnw = 0; cpu_addr = 10'h012; cpu_dout = 8'h34;
        repeat (3) @(negedge clk);
        check("rst_ok", cpu_ok, 0);
        check("rst_din", cpu_din, 0);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_ramdin", ram_din, 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk); check("t1_no_early_we", ram_we, 0);
        @(negedge clk); check("t1_we", ram_we, 1); check("t1_addr", ram_addr, 10'h012);
        @(negedge clk); check("t1_ok", cpu_ok, 1);
        @(posedge clk); #1 cpu_cs = 0; pal[10'h012] = 8'h34;
        @(posedge clk); #1;
        // pixel colour through the one-pixel pipeline
        cpu(0, 10'h212, 8'h56, q);
        pix(9'h012, 6);
        pix(9'h012, 6);
        check("t2_rgb", {red, green, blue}, 15'h5634);
        check("t2_red", red, 5'h15);
        check("t2_green", green, 5'h11);
        check("t2_blue", blue, 5'h14);
        // CPU write then read-back at the top address
        cpu(0, 10'h3FF, 8'hA5, q);
        cpu(1, 10'h3FF, 8'h00, q);
        check("t3_read", q, 8'hA5);
        // CPU request coincident with pxl_cen waits out the video reads
        cpu_cs = 1; cpu_rnw = 0; cpu_addr = 10'h155; cpu_dout = 8'h3C;
        col_addr = 9'h012; pxl_cen = 1;
        @(posedge clk); #1 pxl_cen = 0;
        for (int k = 1; k <= 4; k++) begin @(negedge clk); check("t4_no_grant", ram_we, 0); end
        @(negedge clk); check("t4_grant", ram_we, 1);
        @(negedge clk); check("t4_ok", cpu_ok, 1);
        @(posedge clk); #1 cpu_cs = 0; pal[10'h155] = 8'h3C;
        @(posedge clk); #1;
        pix(9'h012, 6);
        check("t4_video", {red, green, blue}, 15'h5634);
        // long cs hold gives exactly one access; re-assert gives another
        w0 = we_cnt; o0 = ok_cnt; n = 0;
        cpu_cs = 1; cpu_rnw = 0; cpu_addr = 10'h0AA; cpu_dout = 8'h11;
        do begin @(negedge clk); n++; end while (!cpu_ok && n < 20);
        check("t5_ack", cpu_ok, 1);
        repeat (20) @(negedge clk);
        check("t5_one_we", we_cnt - w0, 1);
        check("t5_one_ok", ok_cnt - o0, 1);
        @(posedge clk); #1 cpu_cs = 0; pal[10'h0AA] = 8'h11;
        @(posedge clk); #1;
        cpu(0, 10'h0AA, 8'h22, q);
        cpu(1, 10'h0AA, 8'h00, q);
        check("t5_second", q, 8'h22);
        // col 0x1FF reads bytes 0x1FF and 0x3FF
        cpu(0, 10'h1FF, 8'h0F, q);
        pix(9'h1FF, 6);
        pix(9'h012, 6);
        check("wrap_rgb", {red, green, blue}, 15'h250F);
        // blanking forces black
        LHBL = 0;
        pix(9'h012, 6);
        check("t6_blank", {red, green, blue}, 15'h0);
        LHBL = 1;
        pix(9'h012, 6);
        check("t6_unblank", {red, green, blue}, 15'h5634);
        // blank-only instance: no grant in active video, grant soon after LHBL falls
        cpu_rnw = 0; cpu_addr = 10'h0FF; cpu_dout = 8'h99; cs2 = 1;
        for (int k = 0; k < 10; k++) begin @(negedge clk); check("t6_no_active_grant", we2, 0); end
        @(posedge clk); #1 LHBL = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!we2 && n < 8);
        check("t6_grant_in_4", n <= 4, 1);
        @(negedge clk); check("t6_ok2", ok2, 1);
        @(posedge clk); #1 cs2 = 0; LHBL = 1;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
